// File: rtl/traffic_phase_controller.sv
// N-phase round-robin traffic controller: green/yellow/all-red sequencing with
// demand-driven green extension, latched pedestrian requests and a flashing-yellow mode.
module traffic_phase_controller #(
  parameter int NUM_PHASES  = 4,
  parameter int CNT_W       = 8,
  parameter int GREEN_T     = 15,
  parameter int YELLOW_T    = 3,
  parameter int ALLRED_T    = 2,
  parameter int EXTEND_T    = 5,
  parameter int MAX_GREEN_T = 40,
  parameter int FLASH_T     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_PHASES-1:0]   ped_btn,
  input  logic [NUM_PHASES-1:0]   veh_demand,
  input  logic                    flash_en,
  output logic [3*NUM_PHASES-1:0] lamp_o,
  output logic [NUM_PHASES-1:0]   walk_o,
  output logic [2:0]              phase_o,
  output logic [1:0]              state_o,
  output logic [CNT_W-1:0]        timer_o,
  output logic [NUM_PHASES-1:0]   ped_pend_o
);

  typedef enum logic [1:0] {
    S_GREEN  = 2'b00,
    S_YELLOW = 2'b01,
    S_ALLRED = 2'b10,
    S_FLASH  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0]      GREEN_LD   = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0]      YELLOW_LD  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0]      ALLRED_LD  = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0]      EXTEND_LD  = CNT_W'(EXTEND_T - 1);
  localparam logic [CNT_W-1:0]      FLASH_LD   = CNT_W'(FLASH_T - 1);
  localparam logic [CNT_W:0]        EXT_ADD    = (CNT_W+1)'(EXTEND_T);
  localparam logic [CNT_W:0]        MAX_GREEN  = (CNT_W+1)'(MAX_GREEN_T);
  localparam logic [2:0]            LAST_PHASE = 3'(NUM_PHASES - 1);
  localparam logic [NUM_PHASES-1:0] ONE_HOT0   = {{(NUM_PHASES-1){1'b0}}, 1'b1};

  state_t                r_state, w_state_nxt;
  logic [2:0]            r_phase, w_phase_nxt, w_phase_inc;
  logic [CNT_W-1:0]      r_timer, w_timer_nxt;
  logic [CNT_W-1:0]      r_gcnt, w_gcnt_nxt, w_gcnt_inc;
  logic                  r_blink, w_blink_nxt;
  logic [NUM_PHASES-1:0] r_walk, w_walk_nxt;
  logic [NUM_PHASES-1:0] r_ped_pend, w_pend_clr;
  logic [NUM_PHASES-1:0] r_ped_s1, r_ped_s2, r_ped_prev;
  logic                  r_flash_s1, r_flash_s2;
  logic [NUM_PHASES-1:0] w_ped_edge, w_cur_mask, w_nxt_mask;
  logic [CNT_W:0]        w_ext_sum;
  logic                  w_extend;
  logic [3*NUM_PHASES-1:0] w_lamp;

  assign w_ped_edge  = r_ped_s2 & ~r_ped_prev;
  assign w_phase_inc = (r_phase == LAST_PHASE) ? 3'd0 : r_phase + 3'd1;
  assign w_cur_mask  = ONE_HOT0 << r_phase;
  assign w_nxt_mask  = ONE_HOT0 << w_phase_inc;
  assign w_gcnt_inc  = (r_gcnt == {CNT_W{1'b1}}) ? r_gcnt : r_gcnt + CNT_W'(1);
  // Extension sum is one bit wider than g_cnt so it can never wrap past the cap.
  assign w_ext_sum   = {1'b0, r_gcnt} + EXT_ADD;
  assign w_extend    = (|(veh_demand & w_cur_mask)) &&
                       !(|(r_ped_pend & ~w_cur_mask)) &&
                       (w_ext_sum <= MAX_GREEN);

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_timer_nxt = r_timer - CNT_W'(1);
    w_gcnt_nxt  = r_gcnt;
    w_blink_nxt = r_blink;
    w_walk_nxt  = r_walk;
    w_pend_clr  = '0;
    case (r_state)
      S_GREEN: begin
        w_gcnt_nxt = w_gcnt_inc;
        if (r_flash_s2 || (r_timer == '0 && !w_extend)) begin
          w_state_nxt = S_YELLOW;
          w_timer_nxt = YELLOW_LD;
          w_walk_nxt  = '0;
        end else if (r_timer == '0) begin
          w_timer_nxt = EXTEND_LD;
        end
      end
      S_YELLOW: begin
        if (r_timer == '0) begin
          w_state_nxt = S_ALLRED;
          w_timer_nxt = ALLRED_LD;
        end
      end
      S_ALLRED: begin
        if (r_timer == '0) begin
          if (r_flash_s2) begin
            w_state_nxt = S_FLASH;
            w_timer_nxt = FLASH_LD;
            w_blink_nxt = 1'b1;
          end else begin
            w_state_nxt = S_GREEN;
            w_phase_nxt = w_phase_inc;
            w_timer_nxt = GREEN_LD;
            w_gcnt_nxt  = CNT_W'(1);
            w_walk_nxt  = r_ped_pend & w_nxt_mask;
            w_pend_clr  = w_nxt_mask;
          end
        end
      end
      S_FLASH: begin
        // In flash the timer paces the blink half-period instead of an interval.
        if (!r_flash_s2) begin
          w_state_nxt = S_ALLRED;
          w_timer_nxt = ALLRED_LD;
          w_phase_nxt = LAST_PHASE;
          w_blink_nxt = 1'b1;
        end else if (r_timer == '0) begin
          w_timer_nxt = FLASH_LD;
          w_blink_nxt = ~r_blink;
        end
      end
      default: begin
        w_state_nxt = S_ALLRED;
        w_timer_nxt = ALLRED_LD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_ALLRED;
      r_phase    <= LAST_PHASE;
      r_timer    <= ALLRED_LD;
      r_gcnt     <= '0;
      r_blink    <= 1'b1;
      r_walk     <= '0;
      r_ped_pend <= '0;
      r_ped_s1   <= '0;
      r_ped_s2   <= '0;
      r_ped_prev <= '0;
      r_flash_s1 <= 1'b0;
      r_flash_s2 <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_timer    <= w_timer_nxt;
      r_gcnt     <= w_gcnt_nxt;
      r_blink    <= w_blink_nxt;
      r_walk     <= w_walk_nxt;
      // A fresh edge beats the entry clear, so that request waits a full round.
      r_ped_pend <= (r_ped_pend & ~w_pend_clr) | w_ped_edge;
      r_ped_s1   <= ped_btn;
      r_ped_s2   <= r_ped_s1;
      r_ped_prev <= r_ped_s2;
      r_flash_s1 <= flash_en;
      r_flash_s2 <= r_flash_s1;
    end
  end

  always_comb begin
    w_lamp = '0;
    for (int p = 0; p < NUM_PHASES; p++) begin
      if (r_state == S_FLASH)
        w_lamp[3*p +: 3] = r_blink ? 3'b010 : 3'b000;
      else if (r_phase == 3'(p) && r_state == S_GREEN)
        w_lamp[3*p +: 3] = 3'b001;
      else if (r_phase == 3'(p) && r_state == S_YELLOW)
        w_lamp[3*p +: 3] = 3'b010;
      else
        w_lamp[3*p +: 3] = 3'b100;
    end
  end

  assign lamp_o     = w_lamp;
  assign walk_o     = r_walk;
  assign phase_o    = r_phase;
  assign state_o    = r_state;
  assign timer_o    = r_timer;
  assign ped_pend_o = r_ped_pend;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Self-checking bench for traffic_phase_controller: directed scenarios plus
// randomized traffic compared each cycle against an interval-level reference model.
module tb_traffic_phase_controller;

  localparam int N  = 4;
  localparam int CW = 8;
  localparam int GT = 15;
  localparam int YT = 3;
  localparam int AT = 2;
  localparam int ET = 5;
  localparam int MG = 40;
  localparam int FT = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    ped_btn = '0;
  logic [N-1:0]    veh_demand = '0;
  logic            flash_en = 1'b0;
  logic [3*N-1:0]  lamp_o;
  logic [N-1:0]    walk_o;
  logic [2:0]      phase_o;
  logic [1:0]      state_o;
  logic [CW-1:0]   timer_o;
  logic [N-1:0]    ped_pend_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  traffic_phase_controller #(
    .NUM_PHASES(N), .CNT_W(CW), .GREEN_T(GT), .YELLOW_T(YT), .ALLRED_T(AT),
    .EXTEND_T(ET), .MAX_GREEN_T(MG), .FLASH_T(FT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ped_btn(ped_btn), .veh_demand(veh_demand),
    .flash_en(flash_en), .lamp_o(lamp_o), .walk_o(walk_o), .phase_o(phase_o),
    .state_o(state_o), .timer_o(timer_o), .ped_pend_o(ped_pend_o)
  );

  // Reference model: interval kind (0 green,1 yellow,2 all-red,3 flash), cycles left in it.
  int           m_kind, m_phase, m_left, m_elapsed, m_flash_left;
  bit           m_blink;
  logic [N-1:0] m_pend, m_walk, m_ps1, m_ps2, m_pprev;
  bit           m_fs1, m_fs2;

  function automatic void model_reset();
    m_kind = 2; m_phase = N - 1; m_left = AT; m_elapsed = 0; m_flash_left = 0;
    m_blink = 1'b1; m_pend = '0; m_walk = '0;
    m_ps1 = '0; m_ps2 = '0; m_pprev = '0; m_fs1 = 1'b0; m_fs2 = 1'b0;
  endfunction

  function automatic void model_step();
    logic [N-1:0] edges, clr, others;
    bit fsync;
    edges = m_ps2 & ~m_pprev;
    fsync = m_fs2;
    m_pprev = m_ps2; m_ps2 = m_ps1; m_ps1 = ped_btn;
    m_fs2 = m_fs1; m_fs1 = flash_en;
    clr = '0;
    others = m_pend;
    others[m_phase] = 1'b0;
    case (m_kind)
      0: begin
        if (fsync) begin
          m_kind = 1; m_left = YT; m_walk = '0;
        end else if (m_left > 1) begin
          m_left--; m_elapsed = (m_elapsed < 255) ? m_elapsed + 1 : 255;
        end else if (veh_demand[m_phase] && others == '0 && m_elapsed + ET <= MG) begin
          m_left = ET; m_elapsed = (m_elapsed < 255) ? m_elapsed + 1 : 255;
        end else begin
          m_kind = 1; m_left = YT; m_walk = '0;
        end
      end
      1: begin
        if (m_left > 1) m_left--;
        else begin m_kind = 2; m_left = AT; end
      end
      2: begin
        if (m_left > 1) m_left--;
        else if (fsync) begin
          m_kind = 3; m_blink = 1'b1; m_flash_left = FT;
        end else begin
          m_phase = (m_phase + 1) % N;
          m_kind = 0; m_left = GT; m_elapsed = 1;
          m_walk = '0; m_walk[m_phase] = m_pend[m_phase];
          clr[m_phase] = 1'b1;
        end
      end
      default: begin
        if (!fsync) begin
          m_kind = 2; m_left = AT; m_phase = N - 1;
        end else begin
          m_flash_left--;
          if (m_flash_left == 0) begin m_blink = !m_blink; m_flash_left = FT; end
        end
      end
    endcase
    m_pend = (m_pend & ~clr) | edges;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  function automatic logic [32:0] model_vec();
    logic [3*N-1:0] lamp;
    int t;
    for (int p = 0; p < N; p++) begin
      if (m_kind == 3) lamp[3*p +: 3] = m_blink ? 3'b010 : 3'b000;
      else if (p == m_phase && m_kind == 0) lamp[3*p +: 3] = 3'b001;
      else if (p == m_phase && m_kind == 1) lamp[3*p +: 3] = 3'b010;
      else lamp[3*p +: 3] = 3'b100;
    end
    t = (m_kind == 3) ? 0 : m_left - 1;
    return {lamp, m_walk, 3'(m_phase), 2'(m_kind), 8'(t), m_pend};
  endfunction

  function automatic logic [32:0] dut_vec();
    return {lamp_o, walk_o, phase_o, state_o,
            (state_o == 2'b11) ? 8'd0 : timer_o, ped_pend_o};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic count_while(input logic [1:0] st, output int n);
    n = 0;
    while (state_o === st && n < 300) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_for(input logic [1:0] st, input int ph, input int tm, output bit ok);
    int n;
    n = 0;
    while (!(state_o === st && phase_o === 3'(ph) && (tm < 0 || timer_o === 8'(tm))) && n < 400) begin
      n++;
      tick();
    end
    ok = (n < 400);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (lamp_o !== 12'h924) begin errors++; $display("[TB] FAIL reset_lamp got %h want %h", lamp_o, 12'h924); end
    checks++; if (state_o !== 2'b10) begin errors++; $display("[TB] FAIL reset_state got %b want 10", state_o); end
    checks++; if (phase_o !== 3'd3) begin errors++; $display("[TB] FAIL reset_phase got %0d want 3", phase_o); end
    checks++; if (timer_o !== 8'd1) begin errors++; $display("[TB] FAIL reset_timer got %0d want 1", timer_o); end
    checks++; if (walk_o !== 4'b0 || ped_pend_o !== 4'b0) begin errors++; $display("[TB] FAIL reset_walk_pend got %b/%b want 0000/0000", walk_o, ped_pend_o); end
  endtask

  task automatic test_no_demand();
    int n;
    rst_n = 1'b1;
    n = 0;
    do begin tick(); n++; end while (state_o !== 2'b00 && n < 10);
    checks++; if (n !== 2 || phase_o !== 3'd0 || timer_o !== 8'd14) begin errors++; $display("[TB] FAIL first_green got n=%0d ph=%0d t=%0d want 2/0/14", n, phase_o, timer_o); end
    count_while(2'b00, n);
    checks++; if (n !== GT) begin errors++; $display("[TB] FAIL green_len got %0d want %0d", n, GT); end
    count_while(2'b01, n);
    checks++; if (n !== YT) begin errors++; $display("[TB] FAIL yellow_len got %0d want %0d", n, YT); end
    count_while(2'b10, n);
    checks++; if (n !== AT || state_o !== 2'b00 || phase_o !== 3'd1) begin errors++; $display("[TB] FAIL allred_next got n=%0d st=%b ph=%0d want 2/00/1", n, state_o, phase_o); end
    n = 0;
    do begin tick(); n++; end while (!(state_o === 2'b00 && phase_o === 3'd0) && n < 200);
    checks++; if (n !== 60) begin errors++; $display("[TB] FAIL wrap_to_phase0 got %0d want 60", n); end
  endtask

  task automatic test_extension();
    int n;
    veh_demand = 4'b0001;
    count_while(2'b00, n);
    checks++; if (n !== MG) begin errors++; $display("[TB] FAIL ext_cap got %0d want %0d", n, MG); end
    veh_demand = '0;
    checks++; if (dut_vec() !== model_vec()) begin errors++; $display("[TB] FAIL ext_model got %h want %h", dut_vec(), model_vec()); end
  endtask

  task automatic test_ped();
    int n;
    bit ok, hold;
    wait_for(2'b00, 0, 14, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL ped_wait got timeout want phase0 green"); end
    veh_demand = 4'b0001;
    ped_btn = 4'b0100;
    tick();
    ped_btn = '0;
    tick();
    checks++; if (ped_pend_o[2] !== 1'b0) begin errors++; $display("[TB] FAIL ped_early got %b want 0", ped_pend_o[2]); end
    tick();
    checks++; if (ped_pend_o[2] !== 1'b1) begin errors++; $display("[TB] FAIL ped_latency got %b want 1", ped_pend_o[2]); end
    count_while(2'b00, n);
    checks++; if (n !== 12) begin errors++; $display("[TB] FAIL ped_no_ext got %0d want 12", n); end
    veh_demand = '0;
    wait_for(2'b00, 2, 14, ok);
    checks++; if (!ok || walk_o !== 4'b0100 || ped_pend_o[2] !== 1'b0) begin errors++; $display("[TB] FAIL walk_entry got walk=%b pend=%b want 0100/0", walk_o, ped_pend_o[2]); end
    n = 0; hold = 1'b1;
    while (state_o === 2'b00 && n < 100) begin
      if (walk_o !== 4'b0100) hold = 1'b0;
      n++;
      tick();
    end
    checks++; if (!hold || n !== GT || walk_o !== 4'b0000) begin errors++; $display("[TB] FAIL walk_hold got hold=%0d n=%0d after=%b want 1/15/0000", hold, n, walk_o); end
  endtask

  task automatic test_same_cycle();
    bit ok;
    wait_for(2'b01, 0, 0, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL sc_wait got timeout want phase0 yellow end"); end
    ped_btn = 4'b0010;
    repeat (3) tick();
    checks++; if (state_o !== 2'b00 || phase_o !== 3'd1 || walk_o[1] !== 1'b0 || ped_pend_o[1] !== 1'b1) begin errors++; $display("[TB] FAIL same_cycle got st=%b ph=%0d walk=%b pend=%b want 00/1/0/1", state_o, phase_o, walk_o[1], ped_pend_o[1]); end
    ped_btn = '0;
    tick();
    wait_for(2'b00, 1, 14, ok);
    checks++; if (!ok || walk_o !== 4'b0010 || ped_pend_o[1] !== 1'b0) begin errors++; $display("[TB] FAIL next_round got walk=%b pend=%b want 0010/0", walk_o, ped_pend_o[1]); end
  endtask

  task automatic test_flash();
    int n;
    bit good;
    repeat (4) tick();
    flash_en = 1'b1;
    tick(); tick();
    checks++; if (state_o !== 2'b00) begin errors++; $display("[TB] FAIL flash_sync got %b want 00", state_o); end
    tick();
    checks++; if (state_o !== 2'b01 || phase_o !== 3'd1) begin errors++; $display("[TB] FAIL flash_yellow got st=%b ph=%0d want 01/1", state_o, phase_o); end
    count_while(2'b01, n);
    checks++; if (n !== YT) begin errors++; $display("[TB] FAIL flash_ylen got %0d want %0d", n, YT); end
    count_while(2'b10, n);
    checks++; if (n !== AT || state_o !== 2'b11) begin errors++; $display("[TB] FAIL flash_entry got n=%0d st=%b want 2/11", n, state_o); end
    good = 1'b1;
    for (int i = 0; i < 2 * FT; i++) begin
      if (lamp_o !== ((i < FT) ? 12'h492 : 12'h000) || walk_o !== 4'b0) good = 1'b0;
      tick();
    end
    checks++; if (!good || lamp_o !== 12'h492) begin errors++; $display("[TB] FAIL flash_blink got ok=%0d lamp=%h want 1/492", good, lamp_o); end
    flash_en = 1'b0;
    n = 0;
    while (state_o === 2'b11 && n < 20) begin tick(); n++; end
    checks++; if (n !== 3 || phase_o !== 3'd3) begin errors++; $display("[TB] FAIL flash_exit got n=%0d ph=%0d want 3/3", n, phase_o); end
    count_while(2'b10, n);
    checks++; if (n !== AT || state_o !== 2'b00 || phase_o !== 3'd0) begin errors++; $display("[TB] FAIL flash_resume got n=%0d st=%b ph=%0d want 2/00/0", n, state_o, phase_o); end
  endtask

  task automatic test_reset_mid();
    int n;
    bit ok;
    wait_for(2'b01, 2, 1, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rm_wait got timeout want phase2 yellow"); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (lamp_o !== 12'h924 || state_o !== 2'b10 || timer_o !== 8'd1 || phase_o !== 3'd3) begin errors++; $display("[TB] FAIL reset_mid got lamp=%h st=%b t=%0d ph=%0d want 924/10/1/3", lamp_o, state_o, timer_o, phase_o); end
    tick();
    rst_n = 1'b1;
    n = 0;
    do begin tick(); n++; end while (state_o !== 2'b00 && n < 10);
    checks++; if (n !== 2 || phase_o !== 3'd0) begin errors++; $display("[TB] FAIL restart got n=%0d ph=%0d want 2/0", n, phase_o); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("[TB] FAIL random_cycle%0d got %h want %h", c, dut_vec(), model_vec());
      end
      veh_demand = N'($urandom);
      if ($urandom_range(0, 7) == 0) ped_btn = ped_btn ^ (N'(1) << $urandom_range(0, N - 1));
      if ($urandom_range(0, 149) == 0) flash_en = ~flash_en;
      tick();
    end
    flash_en = 1'b0;
    ped_btn = '0;
    veh_demand = '0;
  endtask

  initial begin
    test_reset();
    test_no_demand();
    test_extension();
    test_ped();
    test_same_cycle();
    test_flash();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
